// File: rtl/prog_delay_ctrl.sv
// prog_delay_ctrl: runtime-programmable delay line built on a circular buffer.
// A write pointer advances every cycle. The read address trails it by
// cur_delay. After reset or any delay change, a FILL phase masks the output
// until the buffer holds cur_delay fresh samples.
// Optional feature macro: PROG_DELAY_STATUS_EN adds the cfg_err output,
// which flags a clamped request.
module prog_delay_ctrl #(
    parameter int DATA_WIDTH    = 12,
    parameter int MAX_DELAY     = 64,
    parameter int DEFAULT_DELAY = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         out_valid,
    input  logic [$clog2(MAX_DELAY):0]   cfg_delay,
    input  logic                         cfg_req,
    output logic                         cfg_ack,
`ifdef PROG_DELAY_STATUS_EN
    output logic                         cfg_err,
`endif
    output logic [$clog2(MAX_DELAY):0]   cur_delay
);

    localparam int AW = $clog2(MAX_DELAY);
    localparam int DW = AW + 1;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [DW-1:0]          fill_cnt_q, fill_cnt_d;
    logic [DW-1:0]          cur_delay_q, cur_delay_d;
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_addr;
    logic                   ack_pend_q, ack_pend_d;
    logic                   cfg_ack_q;
    logic                   out_valid_q;
    logic [DATA_WIDTH-1:0]  data_out_q;
    logic [DW-1:0]          clamped_delay;

    logic [DATA_WIDTH-1:0]  mem [MAX_DELAY];

    // Force a requested delay into the legal range 1..MAX_DELAY.
    always_comb begin
        clamped_delay = cfg_delay;
        if (cfg_delay == '0) begin
            clamped_delay = DW'(1);
        end else if (cfg_delay > DW'(MAX_DELAY)) begin
            clamped_delay = DW'(MAX_DELAY);
        end
    end

    // Next state: a request overrides everything and restarts FILL.
    // Otherwise FILL counts up to cur_delay and then hands over to RUN.
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        cur_delay_d = cur_delay_q;
        ack_pend_d  = 1'b0;
        if (cfg_req) begin
            cur_delay_d = clamped_delay;
            state_d     = FILL;
            fill_cnt_d  = '0;
            ack_pend_d  = 1'b1;
        end else begin
            case (state_q)
                FILL: begin
                    if (fill_cnt_q == cur_delay_q) begin
                        state_d = RUN;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                    end
                end
                RUN:     state_d = RUN;
                default: state_d = FILL;
            endcase
        end
    end

    // Control state registers, the write pointer, and the two-stage ack pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            cur_delay_q <= DW'(DEFAULT_DELAY);
            wr_ptr_q    <= '0;
            ack_pend_q  <= 1'b0;
            cfg_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            cur_delay_q <= cur_delay_d;
            wr_ptr_q    <= wr_ptr_q + 1'b1;
            ack_pend_q  <= ack_pend_d;
            cfg_ack_q   <= ack_pend_q;
        end
    end

    // At a delay of MAX_DELAY the low bits of cur_delay are zero, so the read
    // address equals the write address. The read-before-write port then
    // returns the oldest word.
    assign rd_addr = wr_ptr_q - cur_delay_q[AW-1:0];

    // Buffer write port. Contents are never cleared.
    always_ff @(posedge clk) begin
        mem[wr_ptr_q] <= data_in;
    end

    // Registered read port with output masking: zero unless entering/staying in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (state_d == RUN) begin
            data_out_q  <= mem[rd_addr];
            out_valid_q <= 1'b1;
        end else begin
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end
    end

`ifdef PROG_DELAY_STATUS_EN
    logic req_clamped;
    logic clamp_pend_q;
    logic cfg_err_q;

    assign req_clamped = (cfg_delay == '0) || (cfg_delay > DW'(MAX_DELAY));

    // Carry the clamp flag alongside the ack. Update the error flag when the ack fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            clamp_pend_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            clamp_pend_q <= cfg_req & req_clamped;
            if (ack_pend_q) begin
                cfg_err_q <= clamp_pend_q;
            end
        end
    end

    assign cfg_err = cfg_err_q;
`endif

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign cfg_ack   = cfg_ack_q;
    assign cur_delay = cur_delay_q;

endmodule

// File: tb/tb_prog_delay_ctrl.sv
// Directed testbench for prog_delay_ctrl with default parameters
// (DATA_WIDTH=12, MAX_DELAY=64, DEFAULT_DELAY=10). data_in carries a running
// edge count, and hist[] records the value sampled at each edge.
module tb_prog_delay_ctrl;

    localparam int DW   = 12;
    localparam int CW   = 7;
    localparam int MAXD = 64;
    localparam int DEFD = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic [CW-1:0] cfg_delay = '0;
    logic          cfg_req = 1'b0;
    logic          cfg_ack;
    logic [CW-1:0] cur_delay;
`ifdef PROG_DELAY_STATUS_EN
    logic          cfg_err;
`endif

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    int hist [0:4095];

    always #5 clk = ~clk;

    prog_delay_ctrl #(
        .DATA_WIDTH   (DW),
        .MAX_DELAY    (MAXD),
        .DEFAULT_DELAY(DEFD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (data_out),
        .out_valid(out_valid),
        .cfg_delay(cfg_delay),
        .cfg_req  (cfg_req),
        .cfg_ack  (cfg_ack),
`ifdef PROG_DELAY_STATUS_EN
        .cfg_err  (cfg_err),
`endif
        .cur_delay(cur_delay)
    );

    // Advance one clock edge. Record the word the DUT samples there, then
    // present the next word. Outputs are settled when this returns.
    task automatic tick();
        hist[edge_n + 1] = int'(data_in);
        @(posedge clk);
        #1;
        edge_n++;
        data_in = DW'(edge_n + 1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%0b exp=0", out_valid);
        end
        checks++;
        if (data_out !== '0) begin
            failures++;
            $display("FAIL reset_data got=%0h exp=0", data_out);
        end
        checks++;
        if (cfg_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_ack got=%0b exp=0", cfg_ack);
        end
        checks++;
        if (cur_delay !== CW'(DEFD)) begin
            failures++;
            $display("FAIL reset_cur_delay got=%0d exp=%0d", cur_delay, DEFD);
        end
`ifdef PROG_DELAY_STATUS_EN
        checks++;
        if (cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err got=%0b exp=0", cfg_err);
        end
`endif
        $display("reset done at edge %0d", edge_n);
    endtask

    // From reset, the first sample (edge 1) emerges after edge 11.
    task automatic test_default_delay();
        logic          exp_v;
        logic [DW-1:0] exp_d;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_v = (k >= DEFD + 1);
            exp_d = exp_v ? DW'(hist[edge_n - DEFD]) : '0;
            checks++;
            if (out_valid !== exp_v) begin
                failures++;
                $display("FAIL default_valid k=%0d got=%0b exp=%0b", k, out_valid, exp_v);
            end
            checks++;
            if (data_out !== exp_d) begin
                failures++;
                $display("FAIL default_data k=%0d got=%0h exp=%0h", k, data_out, exp_d);
            end
        end
        $display("default delay run finished at edge %0d", edge_n);
    endtask

    task automatic test_change_delay();
        logic          exp_v;
        logic [DW-1:0] exp_d;
        cfg_req = 1'b1;
        cfg_delay = CW'(3);
        tick();
        cfg_req = 1'b0;
        $display("request delay=3 at edge %0d", edge_n);
        checks++;
        if (cur_delay !== CW'(3) || out_valid !== 1'b0 || cfg_ack !== 1'b0) begin
            failures++;
            $display("FAIL chg_req_edge got=cur%0d/v%0b/ack%0b exp=cur3/v0/ack0",
                     cur_delay, out_valid, cfg_ack);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_v = (k >= 4);
            exp_d = exp_v ? DW'(hist[edge_n - 3]) : '0;
            checks++;
            if (cfg_ack !== (k == 1)) begin
                failures++;
                $display("FAIL chg_ack k=%0d got=%0b exp=%0b", k, cfg_ack, (k == 1));
            end
            checks++;
            if (out_valid !== exp_v || data_out !== exp_d) begin
                failures++;
                $display("FAIL chg_out k=%0d got=v%0b/%0h exp=v%0b/%0h",
                         k, out_valid, data_out, exp_v, exp_d);
            end
        end
    endtask

    // A delay of 0 clamps to 1, and 69 clamps to 64. The 300-cycle run at 64 wraps the pointer.
    task automatic test_clamp();
        logic          exp_v;
        logic [DW-1:0] exp_d;
        cfg_req = 1'b1;
        cfg_delay = CW'(0);
        tick();
        cfg_req = 1'b0;
        $display("request delay=0 at edge %0d", edge_n);
        checks++;
        if (cur_delay !== CW'(1)) begin
            failures++;
            $display("FAIL clamp_low_cur got=%0d exp=1", cur_delay);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_v = (k >= 2);
            exp_d = exp_v ? DW'(hist[edge_n - 1]) : '0;
            checks++;
            if (out_valid !== exp_v || data_out !== exp_d || cfg_ack !== (k == 1)) begin
                failures++;
                $display("FAIL clamp_low k=%0d got=v%0b/%0h/ack%0b exp=v%0b/%0h/ack%0b",
                         k, out_valid, data_out, cfg_ack, exp_v, exp_d, (k == 1));
            end
`ifdef PROG_DELAY_STATUS_EN
            if (k == 1) begin
                checks++;
                if (cfg_err !== 1'b1) begin
                    failures++;
                    $display("FAIL clamp_low_err got=%0b exp=1", cfg_err);
                end
            end
`endif
        end
        cfg_req = 1'b1;
        cfg_delay = CW'(MAXD + 5);
        tick();
        cfg_req = 1'b0;
        $display("request delay=%0d at edge %0d", MAXD + 5, edge_n);
        checks++;
        if (cur_delay !== CW'(MAXD)) begin
            failures++;
            $display("FAIL clamp_high_cur got=%0d exp=%0d", cur_delay, MAXD);
        end
        for (int k = 1; k <= 300; k++) begin
            tick();
            exp_v = (k >= MAXD + 1);
            exp_d = exp_v ? DW'(hist[edge_n - MAXD]) : '0;
            checks++;
            if (out_valid !== exp_v || data_out !== exp_d) begin
                failures++;
                $display("FAIL clamp_high k=%0d got=v%0b/%0h exp=v%0b/%0h",
                         k, out_valid, data_out, exp_v, exp_d);
            end
`ifdef PROG_DELAY_STATUS_EN
            if (k == 1) begin
                checks++;
                if (cfg_err !== 1'b1) begin
                    failures++;
                    $display("FAIL clamp_high_err got=%0b exp=1", cfg_err);
                end
            end
`endif
        end
    endtask

    // Requests on three consecutive edges (5, 20, 7). The last one wins.
    task automatic test_back_to_back();
        logic          exp_v;
        logic [DW-1:0] exp_d;
        int            ack_cnt;
        int            req_vals [3];
        req_vals[0] = 5;
        req_vals[1] = 20;
        req_vals[2] = 7;
        ack_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cfg_req = 1'b1;
            cfg_delay = CW'(req_vals[i]);
            tick();
            $display("request delay=%0d at edge %0d", req_vals[i], edge_n);
            if (cfg_ack === 1'b1) ack_cnt++;
            checks++;
            if (cur_delay !== CW'(req_vals[i]) || cfg_ack !== (i != 0) || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_req i=%0d got=cur%0d/ack%0b/v%0b exp=cur%0d/ack%0b/v0",
                         i, cur_delay, cfg_ack, out_valid, req_vals[i], (i != 0));
            end
        end
        cfg_req = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (cfg_ack === 1'b1) ack_cnt++;
            exp_v = (k >= 8);
            exp_d = exp_v ? DW'(hist[edge_n - 7]) : '0;
            checks++;
            if (out_valid !== exp_v || data_out !== exp_d) begin
                failures++;
                $display("FAIL b2b_out k=%0d got=v%0b/%0h exp=v%0b/%0h",
                         k, out_valid, data_out, exp_v, exp_d);
            end
        end
        checks++;
        if (ack_cnt != 3) begin
            failures++;
            $display("FAIL b2b_ack_count got=%0d exp=3", ack_cnt);
        end
        checks++;
        if (cur_delay !== CW'(7)) begin
            failures++;
            $display("FAIL b2b_final_cur got=%0d exp=7", cur_delay);
        end
    endtask

    task automatic test_reset_mid();
        logic          exp_v;
        logic [DW-1:0] exp_d;
        // Reset while in RUN.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || data_out !== '0 || cur_delay !== CW'(DEFD)) begin
            failures++;
            $display("FAIL rst_run got=v%0b/%0h/cur%0d exp=v0/0/cur%0d",
                     out_valid, data_out, cur_delay, DEFD);
        end
        // Request, then reset plus request on the very next edge.
        cfg_req = 1'b1;
        cfg_delay = CW'(5);
        tick();
        rst = 1'b1;
        cfg_delay = CW'(3);
        tick();
        rst = 1'b0;
        cfg_req = 1'b0;
        $display("reset with request at edge %0d", edge_n);
        checks++;
        if (cfg_ack !== 1'b0 || cur_delay !== CW'(DEFD) || out_valid !== 1'b0 || data_out !== '0) begin
            failures++;
            $display("FAIL rst_req got=ack%0b/cur%0d/v%0b/%0h exp=ack0/cur%0d/v0/0",
                     cfg_ack, cur_delay, out_valid, data_out, DEFD);
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_v = (k >= DEFD + 1);
            exp_d = exp_v ? DW'(hist[edge_n - DEFD]) : '0;
            checks++;
            if (cfg_ack !== 1'b0 || cur_delay !== CW'(DEFD)) begin
                failures++;
                $display("FAIL rst_after k=%0d got=ack%0b/cur%0d exp=ack0/cur%0d",
                         k, cfg_ack, cur_delay, DEFD);
            end
            checks++;
            if (out_valid !== exp_v || data_out !== exp_d) begin
                failures++;
                $display("FAIL rst_refill k=%0d got=v%0b/%0h exp=v%0b/%0h",
                         k, out_valid, data_out, exp_v, exp_d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_delay();
        test_change_delay();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
